mc_ctrl: RTL and testbench

Multi-cycle controller for the MIPS core. It replaces the single-cycle decoder with a FETCH/DECODE/EXEC/MEM/WB state machine that drives the same datapath control fields. It adds a memory ready handshake with a bounded wait timeout, illegal-opcode detection and a retired-instruction counter. It sits between the IR/ALU-flag datapath and the PC/IR/GRF/DM write enables.

---
 rtl/mc_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready
// timeout, illegal-opcode detection and a retired-instruction counter.
module mc_ctrl #(
    parameter int unsigned ALU_CTR_W   = 3,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 memwrite,
    output logic                 regwrite,
    output logic [1:0]           regdst,
    output logic                 alusrc,
    output logic [1:0]           memtoreg,
    output logic [2:0]           npc_sel,
    output logic [1:0]           ext_op,
    output logic [ALU_CTR_W-1:0] alu_ctr,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [CNT_W-1:0]     retired
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    state_e            r_state, w_state_d;
    logic [WAIT_W-1:0] r_wait, w_wait_d;
    logic [CNT_W-1:0]  r_retired;
    logic              w_retire, w_waiting, w_timeout;

    // Instruction decode
    logic [5:0] w_op, w_fn;
    logic [4:0] w_rt;
    logic w_addu, w_subu, w_slt, w_sltu, w_jr, w_addi, w_addiu, w_slti, w_sltiu;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_bne, w_bgez, w_bgtz, w_j, w_jal;
    logic w_branch, w_legal, w_unused;

    assign w_op     = instr[31:26];
    assign w_fn     = instr[5:0];
    assign w_rt     = instr[20:16];
    assign w_unused = ^{instr[25:21], instr[15:6]};

    assign w_addu  = (w_op == 6'h00) && (w_fn == 6'h21);
    assign w_subu  = (w_op == 6'h00) && (w_fn == 6'h23);
    assign w_slt   = (w_op == 6'h00) && (w_fn == 6'h2a);
    assign w_sltu  = (w_op == 6'h00) && (w_fn == 6'h2b);
    assign w_jr    = (w_op == 6'h00) && (w_fn == 6'h08);
    assign w_addi  = (w_op == 6'h08);
    assign w_addiu = (w_op == 6'h09);
    assign w_slti  = (w_op == 6'h0a);
    assign w_sltiu = (w_op == 6'h0b);
    assign w_ori   = (w_op == 6'h0d);
    assign w_lui   = (w_op == 6'h0f);
    assign w_lw    = (w_op == 6'h23);
    assign w_sw    = (w_op == 6'h2b);
    assign w_beq   = (w_op == 6'h04);
    assign w_bne   = (w_op == 6'h05);
    assign w_bgez  = (w_op == 6'h01) && (w_rt == 5'd1);
    assign w_bgtz  = (w_op == 6'h07) && (w_rt == 5'd0);
    assign w_j     = (w_op == 6'h02);
    assign w_jal   = (w_op == 6'h03);

    assign w_branch = w_beq | w_bne | w_bgez | w_bgtz;
    assign w_legal  = w_addu | w_subu | w_slt | w_sltu | w_jr | w_addi | w_addiu | w_slti |
                      w_sltiu | w_ori | w_lui | w_lw | w_sw | w_branch | w_j | w_jal;

    // Only FETCH and MEM wait on memory; a ready on the last allowed cycle beats the timeout
    assign w_waiting = (r_state == StFetch) || (r_state == StMem);
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && !mem_ready && (r_wait == WAIT_LAST);
    assign w_wait_d  = (w_waiting && !mem_ready && !w_timeout) ? r_wait + WAIT_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StFetch;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_retire  = 1'b0;
        case (r_state)
            StFetch: begin
                if (mem_ready) w_state_d = StDecode;
            end
            StDecode: begin
                if (!w_legal) begin
                    w_state_d = StFetch;
                end else if (w_j || w_jr) begin
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                end else if (w_jal) begin
                    w_state_d = StWb;
                end else begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (w_branch) begin
                    w_state_d = StFetch;
                    w_retire  = 1'b1;
                end else if (w_lw || w_sw) begin
                    w_state_d = StMem;
                end else begin
                    w_state_d = StWb;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    w_state_d = w_lw ? StWb : StFetch;
                    w_retire  = !w_lw;
                end else if (w_timeout) begin
                    w_state_d = StFetch;
                end
            end
            StWb: begin
                w_state_d = StFetch;
                w_retire  = 1'b1;
            end
            default: w_state_d = StFetch;
        endcase
    end

    always_comb begin
        logic [2:0] v_alu;
        pc_write = 1'b0;
        ir_write = 1'b0;
        mem_read = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        npc_sel  = 3'b000;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        case (r_state)
            StFetch: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                bus_err  = w_timeout;
            end
            StDecode: begin
                illegal = !w_legal;
                if (w_j || w_jal) begin
                    pc_write = 1'b1;
                    npc_sel  = 3'b010;
                end else if (w_jr) begin
                    pc_write = 1'b1;
                    npc_sel  = 3'b011;
                end
            end
            StExec: begin
                if (w_beq || w_bgez || w_bgtz) begin
                    pc_write = zero;
                    npc_sel  = 3'b001;
                end else if (w_bne) begin
                    pc_write = !zero;
                    npc_sel  = 3'b100;
                end
            end
            StMem: begin
                mem_read = w_lw;
                memwrite = w_sw;
                bus_err  = w_timeout;
            end
            StWb:    regwrite = 1'b1;
            default: ;
        endcase

        // Datapath fields depend only on the instruction
        regdst   = w_jal ? 2'b10 : ((w_addu | w_subu | w_slt | w_sltu) ? 2'b01 : 2'b00);
        alusrc   = w_addi | w_addiu | w_slti | w_sltiu | w_ori | w_lui | w_lw | w_sw;
        memtoreg = w_jal ? 2'b10 : (w_lw ? 2'b01 : 2'b00);
        ext_op   = w_lui ? 2'b10 :
                   ((w_addi | w_addiu | w_slti | w_sltiu | w_lw | w_sw | w_branch) ? 2'b01
                                                                                    : 2'b00);
        v_alu = 3'b000;
        if (w_subu || w_beq || w_bne)      v_alu = 3'b001;
        else if (w_ori)                    v_alu = 3'b010;
        else if (w_slt || w_slti || w_bgez || w_bgtz) v_alu = 3'b011;
        else if (w_sltu || w_sltiu)        v_alu = 3'b100;
        alu_ctr = ALU_CTR_W'(v_alu);

        // Everything is forced low while reset is held so no access survives rst_n falling
        if (!rst_n) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            mem_read = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            regdst   = 2'b00;
            alusrc   = 1'b0;
            memtoreg = 2'b00;
            npc_sel  = 3'b000;
            ext_op   = 2'b00;
            alu_ctr  = '0;
            illegal  = 1'b0;
            bus_err  = 1'b0;
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state and enable checks across the instruction classes,
// memory wait/timeout boundaries, illegal decode and asynchronous reset.
module tb_mc_ctrl;

    logic        clk, rst_n, zero, mem_ready;
    logic [31:0] instr;
    logic        pc_write, ir_write, mem_read, memwrite, regwrite, illegal, bus_err, alusrc;
    logic [1:0]  regdst, memtoreg, ext_op;
    logic [2:0]  npc_sel, alu_ctr, state;
    logic [31:0] retired;
    logic [6:0]  w_en;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    // Enable bundle order: pc_write ir_write mem_read memwrite regwrite illegal bus_err
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_FETCH = 7'b1110000;
    localparam logic [6:0] E_FWAIT = 7'b0010000;
    localparam logic [6:0] E_FERR  = 7'b0010001;
    localparam logic [6:0] E_PC    = 7'b1000000;
    localparam logic [6:0] E_RD    = 7'b0010000;
    localparam logic [6:0] E_WR    = 7'b0001000;
    localparam logic [6:0] E_WRERR = 7'b0001001;
    localparam logic [6:0] E_WB    = 7'b0000100;
    localparam logic [6:0] E_ILL   = 7'b0000010;

    assign w_en = {pc_write, ir_write, mem_read, memwrite, regwrite, illegal, bus_err};

    mc_ctrl #(
        .ALU_CTR_W  (3),
        .CNT_W      (32),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .zero     (zero),
        .mem_ready(mem_ready),
        .pc_write (pc_write),
        .ir_write (ir_write),
        .mem_read (mem_read),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .regdst   (regdst),
        .alusrc   (alusrc),
        .memtoreg (memtoreg),
        .npc_sel  (npc_sel),
        .ext_op   (ext_op),
        .alu_ctr  (alu_ctr),
        .state    (state),
        .illegal  (illegal),
        .bus_err  (bus_err),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check 1 ns later, move to next fall
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic [2:0] st, input logic [6:0] en);
        mem_ready = rdy;
        zero      = z;
        #1;
        chk({tag, "/state"}, {29'd0, state}, {29'd0, st});
        chk({tag, "/en"}, {25'd0, w_en}, {25'd0, en});
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        instr     = I_ADDU;
        @(negedge clk);
        #1;
        chk("rst/en", {25'd0, w_en}, 32'd0);
        chk("rst/state", {29'd0, state}, 32'd0);
        chk("rst/retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addu: 4 cycles, rd write-back
        cyc("addu_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("addu_d", 1'b1, 1'b0, 3'd1, E_NONE);
        cyc("addu_e", 1'b1, 1'b0, 3'd2, E_NONE);
        #1;
        chk("addu_regdst", {30'd0, regdst}, 32'd1);
        chk("addu_alu", {29'd0, alu_ctr}, 32'd0);
        chk("addu_retired0", retired, 32'd0);
        cyc("addu_w", 1'b1, 1'b0, 3'd4, E_WB);
        chk("addu_retired1", retired, 32'd1);

        // lw with two not-ready cycles in MEM: 7 cycles total
        instr = I_LW;
        cyc("lw_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("lw_d", 1'b1, 1'b0, 3'd1, E_NONE);
        #1;
        chk("lw_alusrc", {31'd0, alusrc}, 32'd1);
        chk("lw_ext", {30'd0, ext_op}, 32'd1);
        chk("lw_memtoreg", {30'd0, memtoreg}, 32'd1);
        cyc("lw_e", 1'b1, 1'b0, 3'd2, E_NONE);
        cyc("lw_m0", 1'b0, 1'b0, 3'd3, E_RD);
        cyc("lw_m1", 1'b0, 1'b0, 3'd3, E_RD);
        cyc("lw_m2", 1'b1, 1'b0, 3'd3, E_RD);
        cyc("lw_w", 1'b1, 1'b0, 3'd4, E_WB);
        chk("lw_retired", retired, 32'd2);

        // beq taken then not taken
        instr = I_BEQ;
        cyc("beq1_f", 1'b1, 1'b1, 3'd0, E_FETCH);
        cyc("beq1_d", 1'b1, 1'b1, 3'd1, E_NONE);
        #1;
        chk("beq_alu", {29'd0, alu_ctr}, 32'd1);
        chk("beq1_npc", {29'd0, npc_sel}, 32'd1);
        cyc("beq1_e", 1'b1, 1'b1, 3'd2, E_PC);
        cyc("beq0_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("beq0_d", 1'b1, 1'b0, 3'd1, E_NONE);
        cyc("beq0_e", 1'b1, 1'b0, 3'd2, E_NONE);
        chk("beq_retired", retired, 32'd4);

        // jal: jump in DECODE, link write in WB
        instr = I_JAL;
        cyc("jal_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        #1;
        chk("jal_npc", {29'd0, npc_sel}, 32'd2);
        cyc("jal_d", 1'b1, 1'b0, 3'd1, E_PC);
        #1;
        chk("jal_regdst", {30'd0, regdst}, 32'd2);
        chk("jal_memtoreg", {30'd0, memtoreg}, 32'd2);
        cyc("jal_w", 1'b1, 1'b0, 3'd4, E_WB);
        chk("jal_retired", retired, 32'd5);

        // j: 2 cycles
        instr = I_J;
        cyc("j_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("j_d", 1'b1, 1'b0, 3'd1, E_PC);
        #1;
        chk("j_state", {29'd0, state}, 32'd0);
        chk("j_retired", retired, 32'd6);

        // sw with memory stuck: bus_err on 4th MEM cycle, abort without retiring
        instr = I_SW;
        cyc("swto_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("swto_d", 1'b1, 1'b0, 3'd1, E_NONE);
        cyc("swto_e", 1'b1, 1'b0, 3'd2, E_NONE);
        cyc("swto_m0", 1'b0, 1'b0, 3'd3, E_WR);
        cyc("swto_m1", 1'b0, 1'b0, 3'd3, E_WR);
        cyc("swto_m2", 1'b0, 1'b0, 3'd3, E_WR);
        cyc("swto_m3", 1'b0, 1'b0, 3'd3, E_WRERR);
        cyc("swto_back", 1'b0, 1'b0, 3'd0, E_FWAIT);
        chk("swto_retired", retired, 32'd6);

        // Unsupported opcode 0x3F
        instr = I_BAD;
        cyc("ill_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("ill_d", 1'b1, 1'b0, 3'd1, E_ILL);
        #1;
        chk("ill_state", {29'd0, state}, 32'd0);
        chk("ill_retired", retired, 32'd6);

        // FETCH timeout retries in place
        cyc("fto_0", 1'b0, 1'b0, 3'd0, E_FWAIT);
        cyc("fto_1", 1'b0, 1'b0, 3'd0, E_FWAIT);
        cyc("fto_2", 1'b0, 1'b0, 3'd0, E_FWAIT);
        cyc("fto_3", 1'b0, 1'b0, 3'd0, E_FERR);
        cyc("fto_4", 1'b0, 1'b0, 3'd0, E_FWAIT);

        // lw ready on the last allowed wait cycle: no error
        instr = I_LW;
        cyc("lwrw_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("lwrw_d", 1'b1, 1'b0, 3'd1, E_NONE);
        cyc("lwrw_e", 1'b1, 1'b0, 3'd2, E_NONE);
        cyc("lwrw_m0", 1'b0, 1'b0, 3'd3, E_RD);
        cyc("lwrw_m1", 1'b0, 1'b0, 3'd3, E_RD);
        cyc("lwrw_m2", 1'b0, 1'b0, 3'd3, E_RD);
        cyc("lwrw_m3", 1'b1, 1'b0, 3'd3, E_RD);
        cyc("lwrw_w", 1'b1, 1'b0, 3'd4, E_WB);
        chk("lwrw_retired", retired, 32'd7);

        // Reset in the middle of a sw MEM wait
        instr = I_SW;
        cyc("swrst_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("swrst_d", 1'b1, 1'b0, 3'd1, E_NONE);
        cyc("swrst_e", 1'b1, 1'b0, 3'd2, E_NONE);
        cyc("swrst_m0", 1'b0, 1'b0, 3'd3, E_WR);
        rst_n = 1'b0;
        #1;
        chk("swrst_en", {25'd0, w_en}, 32'd0);
        chk("swrst_state", {29'd0, state}, 32'd0);
        chk("swrst_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_f", 1'b1, 1'b0, 3'd0, E_FETCH);
        cyc("post_d", 1'b1, 1'b0, 3'd1, E_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
